// File: rtl/axi_lite_master.sv
// axi_lite_master: AXI4-Lite initiator for single-beat register reads/writes.
// Accepts one command at a time on cmd_*, runs one AW/W/B or AR/R transaction,
// and returns the result on rsp_* with the transaction latency in cycles.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET   clock, synchronous active-high reset
//   cmd_*                      command request (valid/ready)
//   rsp_*                      result (valid/ready), latency saturates at all-ones
//   busy                       high whenever a command is in flight or pending result
//   M_AXI_*                    AXI4-Lite master channels AW, W, B, AR, R
module axi_lite_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 9,
    parameter int unsigned LAT_WIDTH          = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [LAT_WIDTH-1:0]              rsp_latency,
    output logic                              busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESULT
    } state_e;

    state_e                state_q;
    logic [AW-1:0]         addr_q;
    logic [DW-1:0]         wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  rsp_valid_q;
    logic                  rsp_write_q;
    logic [DW-1:0]         rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic [LAT_WIDTH-1:0]  lat_q;

    // Each write channel is finished once its VALID has dropped or is handshaking now.
    logic aw_done_c;
    logic w_done_c;
    assign aw_done_c = !awvalid_q || M_AXI_AWREADY;
    assign w_done_c  = !wvalid_q  || M_AXI_WREADY;

    // Transaction sequencer with registered bus and result outputs.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            lat_q       <= '0;
        end else begin
            // Latency counts every bus-phase cycle, including the B/R handshake cycle.
            if ((state_q == WR_REQ || state_q == WR_RESP ||
                 state_q == RD_REQ || state_q == RD_DATA) &&
                (lat_q != {LAT_WIDTH{1'b1}})) begin
                lat_q <= lat_q + LAT_WIDTH'(1);
            end

            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        rsp_write_q <= cmd_write;
                        lat_q       <= '0;
                        if (cmd_write) begin
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (awvalid_q && M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done_c && w_done_c) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        rsp_resp_q  <= M_AXI_BRESP;
                        rsp_rdata_q <= '0;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end

                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end

                RESULT: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);

    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_latency   = lat_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: bench for axi_lite_master with a delay-programmable
// AXI4-Lite memory responder and a reference model of memory contents,
// result fields and transaction latency.
module tb_axi_lite_master;

    localparam int unsigned AW = 9;
    localparam int unsigned LW = 16;
    localparam int unsigned WORDS = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [31:0]     cmd_wdata;
    logic [3:0]      cmd_wstrb;
    logic            rsp_valid, rsp_ready, rsp_write;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [LW-1:0]   rsp_latency;
    logic            busy;
    logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic            M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0]     M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]      M_AXI_WSTRB;
    logic            M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY;
    logic            M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi_lite_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (AW),
        .LAT_WIDTH          (LW)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_latency   (rsp_latency),
        .busy          (busy),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    int vectors = 0;
    int miscompares = 0;

    // Responder timing/response knobs, written only by the stimulus block.
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // Responder observations; each written by one responder process only.
    int            aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic [AW-1:0] aw_seen = '0, ar_seen = '0;
    logic [31:0]   w_seen = '0;
    logic [3:0]    ws_seen = '0;
    logic [31:0]   slv_mem [WORDS];

    // Bus monitor counters (cumulative; the stimulus works with deltas).
    int aw_hi = 0, w_hi = 0, ar_hi = 0, moves = 0, early = 0, mixed = 0;

    logic [31:0] ref_mem [WORDS];

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AW responder: raise AWREADY aw_dly cycles after AWVALID is seen.
    initial begin : aw_resp
        int cnt;
        cnt = 0;
        M_AXI_AWREADY = 1'b0;
        forever begin
            @(negedge clk);
            if (!M_AXI_AWVALID) begin
                M_AXI_AWREADY = 1'b0;
                cnt = 0;
            end else if (!M_AXI_AWREADY) begin
                if (cnt >= aw_dly) begin
                    M_AXI_AWREADY = 1'b1;
                    aw_hs++;
                    aw_seen = M_AXI_AWADDR;
                end else cnt++;
            end
        end
    end

    // W responder.
    initial begin : w_resp
        int cnt;
        cnt = 0;
        M_AXI_WREADY = 1'b0;
        forever begin
            @(negedge clk);
            if (!M_AXI_WVALID) begin
                M_AXI_WREADY = 1'b0;
                cnt = 0;
            end else if (!M_AXI_WREADY) begin
                if (cnt >= w_dly) begin
                    M_AXI_WREADY = 1'b1;
                    w_hs++;
                    w_seen  = M_AXI_WDATA;
                    ws_seen = M_AXI_WSTRB;
                end else cnt++;
            end
        end
    end

    // B responder: commits the captured write into responder memory.
    initial begin : b_resp
        int cnt;
        cnt = 0;
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
        for (int i = 0; i < WORDS; i++) slv_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!M_AXI_BREADY) begin
                M_AXI_BVALID = 1'b0;
                cnt = 0;
            end else if (!M_AXI_BVALID) begin
                if (cnt >= b_dly) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = bresp_cfg;
                    slv_mem[aw_seen[8:2]] = merge(slv_mem[aw_seen[8:2]], w_seen, ws_seen);
                end else cnt++;
            end
        end
    end

    // AR responder.
    initial begin : ar_resp
        int cnt;
        cnt = 0;
        M_AXI_ARREADY = 1'b0;
        forever begin
            @(negedge clk);
            if (!M_AXI_ARVALID) begin
                M_AXI_ARREADY = 1'b0;
                cnt = 0;
            end else if (!M_AXI_ARREADY) begin
                if (cnt >= ar_dly) begin
                    M_AXI_ARREADY = 1'b1;
                    ar_hs++;
                    ar_seen = M_AXI_ARADDR;
                end else cnt++;
            end
        end
    end

    // R responder.
    initial begin : r_resp
        int cnt;
        cnt = 0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = '0;
        M_AXI_RRESP  = 2'b00;
        forever begin
            @(negedge clk);
            if (!M_AXI_RREADY) begin
                M_AXI_RVALID = 1'b0;
                cnt = 0;
            end else if (!M_AXI_RVALID) begin
                if (cnt >= r_dly) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA  = slv_mem[ar_seen[8:2]];
                    M_AXI_RRESP  = rresp_cfg;
                end else cnt++;
            end
        end
    end

    // Bus monitor: VALID durations, payload stability and channel exclusivity.
    initial begin : mon
        logic [AW-1:0] pa, pr;
        logic [31:0]   pd;
        logic          pav, pwv, parv;
        pav = 1'b0; pwv = 1'b0; parv = 1'b0; pa = '0; pr = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (M_AXI_AWVALID) aw_hi++;
            if (M_AXI_WVALID)  w_hi++;
            if (M_AXI_ARVALID) ar_hi++;
            if (pav && M_AXI_AWVALID && M_AXI_AWADDR != pa) moves++;
            if (pwv && M_AXI_WVALID && M_AXI_WDATA != pd) moves++;
            if (parv && M_AXI_ARVALID && M_AXI_ARADDR != pr) moves++;
            if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) early++;
            if ((M_AXI_ARVALID || M_AXI_RREADY) &&
                (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY)) mixed++;
            pav = M_AXI_AWVALID; pwv = M_AXI_WVALID; parv = M_AXI_ARVALID;
            pa = M_AXI_AWADDR; pd = M_AXI_WDATA; pr = M_AXI_ARADDR;
        end
    end

    // One complete command: issue, wait for result, check, hold, release.
    task automatic run_cmd(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] st,
                           input int d_aw, input int d_w, input int d_b,
                           input int d_ar, input int d_r, input logic [1:0] resp,
                           input int hold);
        int a0, w0, r0, ah0, wh0, rh0, mv0, e0, m0, exp_lat;
        logic [31:0] exp_rd, hd;
        logic [1:0]  hr;
        logic [LW-1:0] hl;
        bit got, hold_ok;
        aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
        bresp_cfg = resp; rresp_cfg = resp;
        a0 = aw_hs; w0 = w_hs; r0 = ar_hs;
        ah0 = aw_hi; wh0 = w_hi; rh0 = ar_hi; mv0 = moves; e0 = early; m0 = mixed;
        if (wr) begin
            ref_mem[addr[8:2]] = merge(ref_mem[addr[8:2]], wd, st);
            exp_rd  = 32'h0;
            exp_lat = ((d_aw > d_w) ? d_aw : d_w) + d_b + 2;
        end else begin
            exp_rd  = ref_mem[addr[8:2]];
            exp_lat = d_ar + d_r + 2;
        end
        if (exp_lat > 65535) exp_lat = 65535;

        check({tag, ":cmd_ready_idle"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        check({tag, ":busy"}, 64'(busy), 64'(1));

        got = 1'b0;
        for (int i = 0; i < 80000 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, ":rsp_timeout"}, 64'(got), 64'(1));
        if (!got) return;

        check({tag, ":rsp_write"},   64'(rsp_write),   64'(wr));
        check({tag, ":rsp_rdata"},   64'(rsp_rdata),   64'(exp_rd));
        check({tag, ":rsp_resp"},    64'(rsp_resp),    64'(resp));
        check({tag, ":rsp_latency"}, 64'(rsp_latency), 64'(exp_lat));
        check({tag, ":cmd_ready_result"}, 64'(cmd_ready), 64'(0));
        check({tag, ":aw_hs"}, 64'(aw_hs - a0), 64'(wr ? 1 : 0));
        check({tag, ":w_hs"},  64'(w_hs - w0),  64'(wr ? 1 : 0));
        check({tag, ":ar_hs"}, 64'(ar_hs - r0), 64'(wr ? 0 : 1));
        if (wr) begin
            check({tag, ":awaddr"}, 64'(aw_seen), 64'(addr));
            check({tag, ":wdata"},  64'(w_seen),  64'(wd));
            check({tag, ":wstrb"},  64'(ws_seen), 64'(st));
            check({tag, ":awvalid_cycles"}, 64'(aw_hi - ah0), 64'(d_aw + 1));
            check({tag, ":wvalid_cycles"},  64'(w_hi - wh0),  64'(d_w + 1));
            check({tag, ":arvalid_cycles"}, 64'(ar_hi - rh0), 64'(0));
        end else begin
            check({tag, ":araddr"}, 64'(ar_seen), 64'(addr));
            check({tag, ":arvalid_cycles"}, 64'(ar_hi - rh0), 64'(d_ar + 1));
            check({tag, ":awvalid_cycles"}, 64'(aw_hi - ah0), 64'(0));
            check({tag, ":wvalid_cycles"},  64'(w_hi - wh0),  64'(0));
        end
        check({tag, ":payload_moved"}, 64'(moves - mv0), 64'(0));
        check({tag, ":bready_early"},  64'(early - e0),  64'(0));
        check({tag, ":mixed_channels"}, 64'(mixed - m0), 64'(0));

        hold_ok = 1'b1;
        hd = rsp_rdata; hr = rsp_resp; hl = rsp_latency;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== hd || rsp_resp !== hr || rsp_latency !== hl ||
                rsp_write !== wr || cmd_ready || !busy ||
                M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID ||
                M_AXI_BREADY || M_AXI_RREADY) hold_ok = 1'b0;
        end
        if (hold > 0) check({tag, ":hold_stable"}, 64'(hold_ok), 64'(1));

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ":rsp_valid_clr"}, 64'(rsp_valid), 64'(0));
        check({tag, ":cmd_ready_back"}, 64'(cmd_ready), 64'(1));
        check({tag, ":busy_clr"}, 64'(busy), 64'(0));
    endtask

    initial begin : stim
        logic [5:0] idle_bus;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        idle_bus = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                    M_AXI_ARVALID, M_AXI_RREADY, rsp_valid};
        check("reset:valids", 64'(idle_bus), 64'(0));
        check("reset:busy", 64'(busy), 64'(0));
        check("reset:cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset:rsp_fields", {rsp_rdata, 14'(0), rsp_resp, rsp_latency}, 64'(0));
        check("reset:bus_payload", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB, M_AXI_WDATA},
              64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_cmd("wr_basic",  1'b1, 9'h004, 32'h0000_0064, 4'hF, 0, 0, 1, 0, 0, 2'b00, 0);
        run_cmd("rd_basic",  1'b0, 9'h004, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 0);
        run_cmd("wr_skew",   1'b1, 9'h010, 32'hA5A5_1234, 4'h5, 4, 0, 0, 0, 0, 2'b00, 0);
        run_cmd("wr_skew_w", 1'b1, 9'h014, 32'h0BAD_F00D, 4'hC, 0, 3, 2, 0, 0, 2'b01, 0);
        run_cmd("rd_bp",     1'b0, 9'h010, 32'h0,         4'h0, 0, 0, 2, 1, 0, 2'b00, 10);
        run_cmd("rd_sat",    1'b0, 9'h014, 32'h0,         4'h0, 0, 0, 0, 0, 70000, 2'b10, 0);

        // Reset while the write is still waiting for AWREADY.
        aw_dly = 8; w_dly = 0; b_dly = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h020;
        cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort:in_wr_req", 64'(M_AXI_AWVALID), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_bus = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                    M_AXI_ARVALID, M_AXI_RREADY, rsp_valid};
        check("abort:valids", 64'(idle_bus), 64'(0));
        check("abort:busy", 64'(busy), 64'(0));
        check("abort:cmd_ready", 64'(cmd_ready), 64'(1));
        check("abort:latency", 64'(rsp_latency), 64'(0));
        @(negedge clk);
        run_cmd("post_abort_rd", 1'b0, 9'h020, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 1);
        run_cmd("post_abort_wr", 1'b1, 9'h020, 32'h1357_9BDF, 4'h3, 1, 1, 0, 0, 0, 2'b00, 0);

        // Randomized mix over a small address window so reads hit earlier writes.
        for (int n = 0; n < 24; n++) begin
            run_cmd("rand", 1'($urandom), AW'($urandom_range(0, 15) * 4), $urandom,
                    4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 2'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
